// File: rtl/uart_tx.sv
// UART transmitter: one byte per accepted start, 8 data bits LSB first,
// optional even/odd parity, one stop bit, DIV clocks per bit.
module uart_tx #(
    parameter int DIV     = 868,
    parameter int PARIDAD = 0
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic [7:0] dato_i,
    input  logic       start_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int             CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  BAUD_LAST = CW'(DIV - 1);
    localparam logic           ODD_PAR   = (PARIDAD == 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                baud_d = '0;
                bit_d  = 3'd0;
                // Parity is taken from the latched byte, since the shift register is consumed by the time it is sent.
                if (start_i) begin
                    shift_d = dato_i;
                    par_d   = (^dato_i) ^ ODD_PAR;
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        bit_d = 3'd0;
                        if (PARIDAD != 0) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                bit_d   = 3'd0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three DIV=4 instances (no/even/odd parity) and
// one DIV=868 instance share clock, reset, data and start.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [7:0] dato;
    logic       start;
    logic [3:0] tx_w;
    logic [3:0] busy_w;
    logic [3:0] done_w;

    int total;
    int bad;

    uart_tx #(.DIV(4), .PARIDAD(0)) u0 (
        .clk(clk), .rst_i(rst), .dato_i(dato), .start_i(start),
        .tx_o(tx_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]));
    uart_tx #(.DIV(4), .PARIDAD(1)) u1 (
        .clk(clk), .rst_i(rst), .dato_i(dato), .start_i(start),
        .tx_o(tx_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]));
    uart_tx #(.DIV(4), .PARIDAD(2)) u2 (
        .clk(clk), .rst_i(rst), .dato_i(dato), .start_i(start),
        .tx_o(tx_w[2]), .busy_o(busy_w[2]), .done_o(done_w[2]));
    uart_tx #(.DIV(868), .PARIDAD(0)) u3 (
        .clk(clk), .rst_i(rst), .dato_i(dato), .start_i(start),
        .tx_o(tx_w[3]), .busy_o(busy_w[3]), .done_o(done_w[3]));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected {tx, busy, done} at cycle k of a DIV=4 frame started at cycle 0.
    // peven is the hand-computed even-parity bit of d.
    function automatic logic [2:0] exp_vec(input logic [7:0] d, input int pm,
                                           input logic peven, input int k);
        int   n;
        int   slot;
        logic t;
        n = (pm == 0) ? 40 : 44;
        if (k < 1 || k > n + 1) return 3'b100;
        if (k == n + 1) return 3'b101;
        slot = (k - 1) / 4;
        if (slot == 0)                 t = 1'b0;
        else if (slot <= 8)            t = d[slot-1];
        else if (slot == 9 && pm != 0) t = (pm == 1) ? peven : ~peven;
        else                           t = 1'b1;
        return {t, 1'b1, 1'b0};
    endfunction

    task automatic check_vec(input string tag, input int u, input int k, input logic [2:0] e);
        check($sformatf("%s_u%0d_c%0d_tx", tag, u, k), tx_w[u], e[2]);
        check($sformatf("%s_u%0d_c%0d_busy", tag, u, k), busy_w[u], e[1]);
        check($sformatf("%s_u%0d_c%0d_done", tag, u, k), done_w[u], e[0]);
    endtask

    // driver: present a byte during cycle 0, release start in cycle 1
    task automatic send(input logic [7:0] d);
        dato  = d;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    initial begin
        int low_cnt;
        int hi_cnt;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        start = 1'b0;
        dato  = 8'h00;

        // Reset, then idle for 50 cycles
        do_reset(3);
        for (int k = 0; k < 50; k++) begin
            for (int u = 0; u < 4; u++) check_vec("idle", u, k, 3'b100);
            step();
        end

        // 0xA5: even parity 0, odd parity 1
        send(8'hA5);
        for (int k = 1; k <= 46; k++) begin
            for (int u = 0; u < 3; u++) check_vec("a5", u, k, exp_vec(8'hA5, u, 1'b0, k));
            if (k == 38) begin
                check("a5_even_slot", tx_w[1], 1'b0);
                check("a5_odd_slot", tx_w[2], 1'b1);
            end
            step();
        end

        // 0x01: even parity 1
        send(8'h01);
        for (int k = 1; k <= 46; k++) begin
            for (int u = 0; u < 3; u++) check_vec("x01", u, k, exp_vec(8'h01, u, 1'b1, k));
            if (k == 40) check("x01_even_slot", tx_w[1], 1'b1);
            step();
        end
        do_reset(2);

        // Back-to-back with start held and data changed mid-frame
        dato  = 8'h0F;
        start = 1'b1;
        step();
        for (int k = 1; k <= 82; k++) begin
            if (k <= 41) check_vec("b2b1", 0, k, exp_vec(8'h0F, 0, 1'b0, k));
            else         check_vec("b2b2", 0, k, exp_vec(8'hF0, 0, 1'b0, k - 41));
            if (k == 10) dato = 8'hF0;
            step();
        end
        start = 1'b0;
        do_reset(2);

        // Reset in the middle of a frame, then a fresh frame
        send(8'hA5);
        for (int k = 1; k <= 24; k++) begin
            if (k <= 20) check_vec("mid", 0, k, exp_vec(8'hA5, 0, 1'b0, k));
            else         check_vec("mid_rst", 0, k, 3'b100);
            if (k == 20) rst = 1'b1;
            if (k == 21) rst = 1'b0;
            step();
        end
        send(8'h3C);
        for (int k = 1; k <= 42; k++) begin
            check_vec("after", 0, k, exp_vec(8'h3C, 0, 1'b0, k));
            step();
        end

        // Reset and start together: reset wins
        rst   = 1'b1;
        start = 1'b1;
        dato  = 8'hFF;
        step();
        rst   = 1'b0;
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            check_vec("rst_start", 0, k, 3'b100);
            step();
        end

        // Baud accuracy at DIV=868 with 0x00
        do_reset(2);
        send(8'h00);
        low_cnt = 0;
        while (tx_w[3] == 1'b0 && low_cnt < 10000) begin
            low_cnt++;
            step();
        end
        check("baud_low_run", low_cnt, 7812);
        hi_cnt = 0;
        while (tx_w[3] == 1'b1 && busy_w[3] == 1'b1 && hi_cnt < 2000) begin
            hi_cnt++;
            step();
        end
        check("baud_stop_run", hi_cnt, 868);
        check("baud_done", done_w[3], 1'b1);
        check("baud_idle_busy", busy_w[3], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
